eth_frame_checker: RTL and testbench

ETH_FRAME_CHECKER -- requirements
Module: eth_frame_checker

---
 rtl/eth_frame_checker.sv | 221 ++++++++++++++++++++++
 tb/tb_eth_frame_checker.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_frame_checker.sv
// Ethernet RX frame checker: captures header fields and checks FCS, length,
// format and destination address of each frame delivered by a GMII byte parser.
//   clk, rst               : clock, synchronous active-high reset
//   gmii_valid_i/data_i    : one GMII RX byte per cycle
//   is_*_i                 : parser field flags for the current byte
//   parser_*_i             : parser error pulses
//   own_mac_i/promiscuous_i: address filter configuration
//   hdr_valid_o, dst/src_mac_o, ether_type_o : captured header, pulse when valid
//   frame_done_o + status  : per-frame status, pulse when valid, held until next
module eth_frame_checker #(
  parameter int unsigned MIN_FRAME_LEN = 64,
  parameter int unsigned MAX_FRAME_LEN = 1518
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        gmii_valid_i,
  input  logic [7:0]  gmii_data_i,
  input  logic        is_preamble_or_sfd_i,
  input  logic        is_dst_mac_i,
  input  logic        is_src_mac_i,
  input  logic        is_ether_type_i,
  input  logic        is_payload_or_crc_i,
  input  logic        parser_incomplete_i,
  input  logic        parser_preamble_err_i,
  input  logic [47:0] own_mac_i,
  input  logic        promiscuous_i,
  output logic        hdr_valid_o,
  output logic [47:0] dst_mac_o,
  output logic [47:0] src_mac_o,
  output logic [15:0] ether_type_o,
  output logic        frame_done_o,
  output logic        frame_good_o,
  output logic        fcs_err_o,
  output logic        len_err_o,
  output logic        fmt_err_o,
  output logic        addr_match_o,
  output logic [10:0] frame_len_o
);

  localparam int unsigned LEN_W = 11;
  localparam logic [LEN_W-1:0] LEN_SAT     = '1;
  localparam logic [31:0]      CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0]      CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0]      CRC_RESIDUE = 32'hDEBB_20E3;

  typedef enum logic [1:0] {IDLE, HDR, BODY} state_e;

  // Byte-wise reflected CRC-32 update
  function automatic logic [31:0] crc_next(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        crc_q, crc_d;
  logic               et_cnt_q, et_cnt_d;
  logic               sticky_q, sticky_d;
  logic [47:0]        dst_q, dst_d, src_q, src_d;
  logic [15:0]        et_q, et_d;
  logic               hdr_valid_q, hdr_valid_d;
  logic               done_q, done_d;
  logic               good_q, good_d, fcs_q, fcs_d, len_err_q, len_err_d;
  logic               fmt_q, fmt_d, match_q, match_d;
  logic [LEN_W-1:0]   flen_q, flen_d;

  // Field flags already identify the frame; preamble flag carries no extra info here
  logic unused_inputs;
  assign unused_inputs = is_preamble_or_sfd_i;

  logic             counted;
  logic             fmt_set;
  logic [LEN_W-1:0] cnt_inc;
  logic             start, finish, abort;

  always_comb begin
    counted  = is_dst_mac_i | is_src_mac_i | is_ether_type_i | is_payload_or_crc_i;
    fmt_set  = parser_preamble_err_i | (parser_incomplete_i & (state_q != BODY));
    cnt_inc  = (cnt_q == LEN_SAT) ? cnt_q : cnt_q + LEN_W'(1);

    state_d     = state_q;
    cnt_d       = cnt_q;
    crc_d       = crc_q;
    et_cnt_d    = et_cnt_q;
    dst_d       = dst_q;
    src_d       = src_q;
    et_d        = et_q;
    hdr_valid_d = 1'b0;
    done_d      = 1'b0;
    good_d      = good_q;
    fcs_d       = fcs_q;
    len_err_d   = len_err_q;
    fmt_d       = fmt_q;
    match_d     = match_q;
    flen_d      = flen_q;
    start       = 1'b0;
    finish      = 1'b0;
    abort       = 1'b0;
    // Clear on the done cycle, but a new error in that same cycle survives
    sticky_d    = done_q ? fmt_set : (sticky_q | fmt_set);

    unique case (state_q)
      IDLE: begin
        if (is_dst_mac_i) begin
          start = 1'b1;
        end
      end
      HDR: begin
        if (parser_incomplete_i || !gmii_valid_i) begin
          abort   = 1'b1;
          finish  = 1'b1;
          state_d = IDLE;
        end else begin
          if (counted) begin
            cnt_d = cnt_inc;
            crc_d = crc_next(crc_q, gmii_data_i);
          end
          if (is_dst_mac_i)    dst_d = {dst_q[39:0], gmii_data_i};
          if (is_src_mac_i)    src_d = {src_q[39:0], gmii_data_i};
          if (is_ether_type_i) begin
            et_d = {et_q[7:0], gmii_data_i};
            if (et_cnt_q) begin
              et_cnt_d    = 1'b0;
              state_d     = BODY;
              hdr_valid_d = 1'b1;
            end else begin
              et_cnt_d = 1'b1;
            end
          end
        end
      end
      BODY: begin
        if (is_payload_or_crc_i) begin
          cnt_d = cnt_inc;
          crc_d = crc_next(crc_q, gmii_data_i);
        end else begin
          finish  = 1'b1;
          state_d = IDLE;
          // A dst byte right at end-detect opens the next frame immediately
          if (is_dst_mac_i) start = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Status uses the completed frame's registers, before any restart overwrites them
    if (finish) begin
      done_d    = 1'b1;
      fcs_d     = (crc_q != CRC_RESIDUE);
      len_err_d = (32'(cnt_q) < MIN_FRAME_LEN) || (32'(cnt_q) > MAX_FRAME_LEN);
      fmt_d     = sticky_q | fmt_set | abort;
      match_d   = promiscuous_i || (dst_q == own_mac_i) || (dst_q == 48'hFFFF_FFFF_FFFF)
                  || dst_q[40];
      good_d    = !fcs_d && !len_err_d && !fmt_d && match_d;
      flen_d    = cnt_q;
    end

    if (start) begin
      state_d  = HDR;
      cnt_d    = LEN_W'(1);
      crc_d    = crc_next(CRC_INIT, gmii_data_i);
      dst_d    = {dst_q[39:0], gmii_data_i};
      et_cnt_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      crc_q       <= CRC_INIT;
      et_cnt_q    <= 1'b0;
      sticky_q    <= 1'b0;
      dst_q       <= '0;
      src_q       <= '0;
      et_q        <= '0;
      hdr_valid_q <= 1'b0;
      done_q      <= 1'b0;
      good_q      <= 1'b0;
      fcs_q       <= 1'b0;
      len_err_q   <= 1'b0;
      fmt_q       <= 1'b0;
      match_q     <= 1'b0;
      flen_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      crc_q       <= crc_d;
      et_cnt_q    <= et_cnt_d;
      sticky_q    <= sticky_d;
      dst_q       <= dst_d;
      src_q       <= src_d;
      et_q        <= et_d;
      hdr_valid_q <= hdr_valid_d;
      done_q      <= done_d;
      good_q      <= good_d;
      fcs_q       <= fcs_d;
      len_err_q   <= len_err_d;
      fmt_q       <= fmt_d;
      match_q     <= match_d;
      flen_q      <= flen_d;
    end
  end

  assign hdr_valid_o  = hdr_valid_q;
  assign dst_mac_o    = dst_q;
  assign src_mac_o    = src_q;
  assign ether_type_o = et_q;
  assign frame_done_o = done_q;
  assign frame_good_o = good_q;
  assign fcs_err_o    = fcs_q;
  assign len_err_o    = len_err_q;
  assign fmt_err_o    = fmt_q;
  assign addr_match_o = match_q;
  assign frame_len_o  = flen_q;

endmodule

// File: tb/tb_eth_frame_checker.sv
// Scoreboard bench for eth_frame_checker: directed frames, expectations queued
// at stimulus time, popped and compared by a monitor on each output pulse.
module tb_eth_frame_checker;

  localparam logic [47:0] OWN   = 48'h0011_2233_4455;
  localparam logic [47:0] SRC   = 48'h00AA_BBCC_DDEE;
  localparam logic [15:0] ET    = 16'h0800;
  localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] MCAST = 48'h0100_5E00_0001;
  localparam logic [47:0] UNI   = 48'h0200_0000_0099;

  logic        clk = 1'b0;
  logic        rst;
  logic        gmii_valid_i;
  logic [7:0]  gmii_data_i;
  logic        is_preamble_or_sfd_i, is_dst_mac_i, is_src_mac_i, is_ether_type_i;
  logic        is_payload_or_crc_i, parser_incomplete_i, parser_preamble_err_i;
  logic [47:0] own_mac_i;
  logic        promiscuous_i;
  logic        hdr_valid_o, frame_done_o, frame_good_o, fcs_err_o, len_err_o;
  logic        fmt_err_o, addr_match_o;
  logic [47:0] dst_mac_o, src_mac_o;
  logic [15:0] ether_type_o;
  logic [10:0] frame_len_o;

  eth_frame_checker dut (
    .clk(clk), .rst(rst),
    .gmii_valid_i(gmii_valid_i), .gmii_data_i(gmii_data_i),
    .is_preamble_or_sfd_i(is_preamble_or_sfd_i), .is_dst_mac_i(is_dst_mac_i),
    .is_src_mac_i(is_src_mac_i), .is_ether_type_i(is_ether_type_i),
    .is_payload_or_crc_i(is_payload_or_crc_i), .parser_incomplete_i(parser_incomplete_i),
    .parser_preamble_err_i(parser_preamble_err_i), .own_mac_i(own_mac_i),
    .promiscuous_i(promiscuous_i), .hdr_valid_o(hdr_valid_o), .dst_mac_o(dst_mac_o),
    .src_mac_o(src_mac_o), .ether_type_o(ether_type_o), .frame_done_o(frame_done_o),
    .frame_good_o(frame_good_o), .fcs_err_o(fcs_err_o), .len_err_o(len_err_o),
    .fmt_err_o(fmt_err_o), .addr_match_o(addr_match_o), .frame_len_o(frame_len_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic good, fcs, len, fmt, match;
    logic [10:0] flen;
    bit full;
  } exp_t;
  typedef struct {
    logic [47:0] dst, src;
    logic [15:0] et;
  } hdr_t;

  exp_t q_exp[$];
  hdr_t q_hdr[$];
  logic [7:0] frm[$];
  int compares = 0, mism = 0;
  int n_done_seen = 0, n_done_pushed = 0, n_hdr_seen = 0, n_hdr_pushed = 0;
  exp_t mon_e;
  hdr_t mon_h;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compares++;
    if (act !== exp) begin
      mism++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference FCS, computed bit-serially (LSB first) and complemented
  function automatic logic [31:0] tb_fcs(input logic [7:0] q[$]);
    logic [31:0] c;
    logic fb;
    c = 32'hFFFF_FFFF;
    foreach (q[i]) begin
      for (int k = 0; k < 8; k++) begin
        fb = c[0] ^ q[i][k];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB8_8320;
      end
    end
    return ~c;
  endfunction

  task automatic build(input logic [47:0] dst, input int npay, input int flip_byte);
    logic [31:0] fcs;
    frm.delete();
    for (int i = 5; i >= 0; i--) frm.push_back(dst[i*8 +: 8]);
    for (int i = 5; i >= 0; i--) frm.push_back(SRC[i*8 +: 8]);
    frm.push_back(ET[15:8]);
    frm.push_back(ET[7:0]);
    for (int i = 0; i < npay; i++) frm.push_back(8'(i * 7 + 3));
    fcs = tb_fcs(frm);
    for (int k = 0; k < 4; k++) frm.push_back(fcs[k*8 +: 8]);
    if (flip_byte >= 0) frm[14 + flip_byte] = frm[14 + flip_byte] ^ 8'h01;
  endtask

  // flags = {pre, dst, src, et, pl}
  task automatic drive(input logic v, input logic [7:0] d, input logic [4:0] f, input logic perr);
    gmii_valid_i          = v;
    gmii_data_i           = d;
    is_preamble_or_sfd_i  = f[4];
    is_dst_mac_i          = f[3];
    is_src_mac_i          = f[2];
    is_ether_type_i       = f[1];
    is_payload_or_crc_i   = f[0];
    parser_preamble_err_i = perr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 5'b00000, 1'b0);
  endtask

  // mode 0: full frame, 1: gmii_valid drop after cut bytes, 2: rst after cut bytes
  task automatic send(input int mode, input int cut, input bit perr);
    int n;
    logic [4:0] f;
    n = (mode != 0) ? cut : frm.size();
    for (int i = 0; i < 8; i++) drive(1'b1, (i == 7) ? 8'hD5 : 8'h55, 5'b10000, perr && i == 3);
    for (int i = 0; i < n; i++) begin
      f = (i < 6) ? 5'b01000 : (i < 12) ? 5'b00100 : (i < 14) ? 5'b00010 : 5'b00001;
      drive(1'b1, frm[i], f, 1'b0);
    end
    if (mode == 1) idle(1);
    if (mode == 2) begin
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
    end
  endtask

  task automatic push_hdr(input logic [47:0] dst);
    q_hdr.push_back('{dst: dst, src: SRC, et: ET});
    n_hdr_pushed++;
  endtask

  task automatic push_exp(input logic good, fcs, len, fmt, match, input int flen, input bit full);
    q_exp.push_back('{good: good, fcs: fcs, len: len, fmt: fmt, match: match,
                      flen: 11'(flen), full: full});
    n_done_pushed++;
  endtask

  // Frame with header, full-status expectation
  task automatic frame(input logic [47:0] dst, input int npay, input int flip, input bit perr,
                       input logic good, fcs, len, fmt, match);
    build(dst, npay, flip);
    push_hdr(dst);
    push_exp(good, fcs, len, fmt, match, 18 + npay, 1'b1);
    send(0, 0, perr);
  endtask

  // Monitor: each output pulse consumes one queued expectation
  always @(negedge clk) begin
    if (hdr_valid_o) begin
      n_hdr_seen++;
      if (q_hdr.size() == 0) begin
        compares++; mism++;
        $display("FAIL hdr_unexpected: got hdr_valid_o=1 expected none at %0t", $time);
      end else begin
        mon_h = q_hdr.pop_front();
        chk("dst_mac", 64'(dst_mac_o), 64'(mon_h.dst));
        chk("src_mac", 64'(src_mac_o), 64'(mon_h.src));
        chk("ether_type", 64'(ether_type_o), 64'(mon_h.et));
      end
    end
    if (frame_done_o) begin
      n_done_seen++;
      if (q_exp.size() == 0) begin
        compares++; mism++;
        $display("FAIL done_unexpected: got frame_done_o=1 expected none at %0t", $time);
      end else begin
        mon_e = q_exp.pop_front();
        chk("frame_good", 64'(frame_good_o), 64'(mon_e.good));
        chk("fmt_err", 64'(fmt_err_o), 64'(mon_e.fmt));
        chk("addr_match", 64'(addr_match_o), 64'(mon_e.match));
        if (mon_e.full) begin
          chk("fcs_err", 64'(fcs_err_o), 64'(mon_e.fcs));
          chk("len_err", 64'(len_err_o), 64'(mon_e.len));
          chk("frame_len", 64'(frame_len_o), 64'(mon_e.flen));
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    own_mac_i = OWN;
    promiscuous_i = 1'b0;
    parser_incomplete_i = 1'b0;
    idle(3);
    chk("rst_hdr_valid", 64'(hdr_valid_o), 64'd0);
    chk("rst_frame_done", 64'(frame_done_o), 64'd0);
    chk("rst_frame_good", 64'(frame_good_o), 64'd0);
    chk("rst_fcs_err", 64'(fcs_err_o), 64'd0);
    chk("rst_len_err", 64'(len_err_o), 64'd0);
    chk("rst_fmt_err", 64'(fmt_err_o), 64'd0);
    chk("rst_addr_match", 64'(addr_match_o), 64'd0);
    chk("rst_frame_len", 64'(frame_len_o), 64'd0);
    chk("rst_dst", 64'(dst_mac_o), 64'd0);
    chk("rst_src", 64'(src_mac_o), 64'd0);
    chk("rst_et", 64'(ether_type_o), 64'd0);
    rst = 1'b0;
    idle(2);

    //     dst    npay  flip perr  good fcs len fmt match
    frame(OWN,   46,   -1,  0,    1,   0,  0,  0,  1);   // 64 B good
    frame(OWN,   46,   10,  0,    0,   1,  0,  0,  1);   // bit flip
    frame(OWN,   42,   -1,  0,    0,   0,  1,  0,  1);   // 60 B runt
    frame(OWN,   1501, -1,  0,    0,   0,  1,  0,  1);   // 1519 B giant

    // Header truncated by gmii_valid drop after 8 address bytes
    build(OWN, 46, -1);
    push_exp(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8, 1'b0);
    send(1, 8, 1'b0);

    frame(OWN,   46,   -1,  0,    1,   0,  0,  0,  1);   // clean after abort
    frame(BCAST, 46,   -1,  0,    1,   0,  0,  0,  1);
    frame(MCAST, 46,   -1,  0,    1,   0,  0,  0,  1);
    frame(UNI,   46,   -1,  0,    0,   0,  0,  0,  0);
    idle(2);
    promiscuous_i = 1'b1;
    frame(UNI,   46,   -1,  0,    1,   0,  0,  0,  1);
    idle(2);
    promiscuous_i = 1'b0;
    frame(OWN,   46,   -1,  1,    0,   0,  0,  1,  1);   // preamble error
    frame(OWN,   46,   -1,  0,    1,   0,  0,  0,  1);   // sticky cleared

    // Reset mid-body: header pulses, but no frame_done
    build(OWN, 46, -1);
    push_hdr(OWN);
    send(2, 20, 1'b0);

    frame(OWN,   46,   -1,  0,    1,   0,  0,  0,  1);
    idle(5);

    for (int t = 0; t < 200 && (q_exp.size() != 0 || q_hdr.size() != 0); t++) idle(1);
    chk("queue_drained", 64'(q_exp.size() + q_hdr.size()), 64'd0);
    chk("done_pulse_cycles", 64'(n_done_seen), 64'(n_done_pushed));
    chk("hdr_pulse_cycles", 64'(n_hdr_seen), 64'(n_hdr_pushed));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mism);
    $finish;
  end

endmodule
